cache_mem_ctrl: RTL

- Sequences block transfers between the 4-way cache datapath and a word-wide backing-memory port.
- Serialises a 64 B victim writeback into 16 write beats and gathers 16 read beats into a refill block.
- Sits between the cache control unit's block-level memory interface and the memory model/bus.
- One combined request can perform writeback-then-refill, which is the dirty-miss case.

---
 rtl/cache_mem_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/cache_mem_ctrl.sv
// Block transfer sequencer between the cache and a word-wide memory port: writeback, refill, or both.
// Optional watchdog abort is compiled in with `define CACHE_MEM_TIMEOUT_EN.
module cache_mem_ctrl #(
  parameter int unsigned PA_WIDTH      = 32,
  parameter int unsigned WRD_WIDTH     = 32,
  parameter int unsigned WORDS_PER_BLK = 16,
  parameter int unsigned BLK_WIDTH     = 512,
  parameter int unsigned TIMEOUT_CYC   = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic                 req_rd,
  input  logic [PA_WIDTH-1:0]  req_wr_addr,
  input  logic [PA_WIDTH-1:0]  req_rd_addr,
  input  logic [BLK_WIDTH-1:0] req_wr_blk,
  output logic                 rsp_valid,
  output logic                 rsp_err,
  output logic [BLK_WIDTH-1:0] rsp_rd_blk,
  output logic                 m_cmd_valid,
  input  logic                 m_cmd_ready,
  output logic                 m_cmd_wr,
  output logic [PA_WIDTH-1:0]  m_cmd_addr,
  output logic [WRD_WIDTH-1:0] m_wdata,
  input  logic                 m_rdata_valid,
  input  logic [WRD_WIDTH-1:0] m_rdata
);

  localparam int unsigned IDX_W   = $clog2(WORDS_PER_BLK);
  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam int unsigned OFF_W   = $clog2(WRD_WIDTH / 8);
  localparam int unsigned BLK_OFF = IDX_W + OFF_W;
  localparam int unsigned BASE_W  = PA_WIDTH - BLK_OFF;

  if (BLK_WIDTH != WRD_WIDTH * WORDS_PER_BLK || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("cache_mem_ctrl: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, WB, RD, DONE} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cmd_cnt_q;
  logic [CNT_W-1:0]     rx_cnt_q;
  logic [BASE_W-1:0]    wr_base_q;
  logic [BASE_W-1:0]    rd_base_q;
  logic [BLK_WIDTH-1:0] wr_blk_q;
  logic                 rd_q;
  logic [BLK_WIDTH-1:0] asm_q;
  logic [BLK_WIDTH-1:0] asm_d;
  logic [BLK_WIDTH-1:0] rsp_rd_blk_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic                 m_cmd_valid_q;
  logic                 m_cmd_wr_q;
  logic [PA_WIDTH-1:0]  m_cmd_addr_q;
  logic [WRD_WIDTH-1:0] m_wdata_q;
  logic                 cmd_fire;
  logic                 rx_fire;
  logic                 rx_last;
  logic                 cmd_last;
  logic [IDX_W-1:0]     cmd_nxt;
  logic                 unused_addr_bits;

`ifdef CACHE_MEM_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q;
`endif

  function automatic logic [PA_WIDTH-1:0] beat_addr(input logic [BASE_W-1:0] base,
                                                    input logic [IDX_W-1:0]  k);
    return {base, k, {OFF_W{1'b0}}};
  endfunction

  // Word k sits at the MSB end for k = 0 (big-endian word order).
  function automatic logic [WRD_WIDTH-1:0] blk_word(input logic [BLK_WIDTH-1:0] blk,
                                                    input logic [IDX_W-1:0]     k);
    return blk[BLK_WIDTH-1-WRD_WIDTH*int'(k) -: WRD_WIDTH];
  endfunction

  assign unused_addr_bits = ^{req_wr_addr[BLK_OFF-1:0], req_rd_addr[BLK_OFF-1:0]};

  assign cmd_fire = m_cmd_valid_q & m_cmd_ready;
  assign rx_fire  = (state_q == RD) & m_rdata_valid & ~rx_cnt_q[IDX_W];
  assign rx_last  = (rx_cnt_q == CNT_W'(WORDS_PER_BLK - 1));
  assign cmd_last = (cmd_cnt_q == CNT_W'(WORDS_PER_BLK - 1));
  assign cmd_nxt  = IDX_W'(cmd_cnt_q + CNT_W'(1));

  // Refill assembly: drop the arriving word into its slot.
  always_comb begin
    asm_d = asm_q;
    asm_d[BLK_WIDTH-1-WRD_WIDTH*int'(rx_cnt_q[IDX_W-1:0]) -: WRD_WIDTH] = m_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_cnt_q     <= '0;
      rx_cnt_q      <= '0;
      wr_base_q     <= '0;
      rd_base_q     <= '0;
      wr_blk_q      <= '0;
      rd_q          <= 1'b0;
      asm_q         <= '0;
      rsp_rd_blk_q  <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      m_cmd_valid_q <= 1'b0;
      m_cmd_wr_q    <= 1'b0;
      m_cmd_addr_q  <= '0;
      m_wdata_q     <= '0;
`ifdef CACHE_MEM_TIMEOUT_EN
      wdog_q        <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            wr_base_q   <= req_wr_addr[PA_WIDTH-1:BLK_OFF];
            rd_base_q   <= req_rd_addr[PA_WIDTH-1:BLK_OFF];
            wr_blk_q    <= req_wr_blk;
            rd_q        <= req_rd;
            cmd_cnt_q   <= '0;
            rx_cnt_q    <= '0;
            req_ready_q <= 1'b0;
            if (req_wr) begin
              state_q       <= WB;
              m_cmd_valid_q <= 1'b1;
              m_cmd_wr_q    <= 1'b1;
              m_cmd_addr_q  <= beat_addr(req_wr_addr[PA_WIDTH-1:BLK_OFF], '0);
              m_wdata_q     <= blk_word(req_wr_blk, '0);
            end else if (req_rd) begin
              state_q       <= RD;
              m_cmd_valid_q <= 1'b1;
              m_cmd_wr_q    <= 1'b0;
              m_cmd_addr_q  <= beat_addr(req_rd_addr[PA_WIDTH-1:BLK_OFF], '0);
            end else begin
              state_q     <= DONE;
              rsp_valid_q <= 1'b1;
            end
          end
        end
        WB: begin
          if (cmd_fire) begin
            if (cmd_last) begin
              cmd_cnt_q  <= '0;
              m_cmd_wr_q <= 1'b0;
              if (rd_q) begin
                state_q      <= RD;
                m_cmd_addr_q <= beat_addr(rd_base_q, '0);
              end else begin
                state_q       <= DONE;
                m_cmd_valid_q <= 1'b0;
                rsp_valid_q   <= 1'b1;
              end
            end else begin
              cmd_cnt_q    <= cmd_cnt_q + CNT_W'(1);
              m_cmd_addr_q <= beat_addr(wr_base_q, cmd_nxt);
              m_wdata_q    <= blk_word(wr_blk_q, cmd_nxt);
            end
          end
        end
        RD: begin
          // Commands run ahead of returning data; the two counters are independent.
          if (cmd_fire) begin
            cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
            if (cmd_last) m_cmd_valid_q <= 1'b0;
            else          m_cmd_addr_q  <= beat_addr(rd_base_q, cmd_nxt);
          end
          if (rx_fire) begin
            asm_q    <= asm_d;
            rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            if (rx_last) begin
              state_q       <= DONE;
              rsp_valid_q   <= 1'b1;
              rsp_rd_blk_q  <= asm_d;
              m_cmd_valid_q <= 1'b0;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
`ifdef CACHE_MEM_TIMEOUT_EN
      // Watchdog: any beat of progress rearms it; expiry abandons the transfer.
      if (state_q == WB || state_q == RD) begin
        if (cmd_fire || rx_fire) begin
          wdog_q <= '0;
        end else if (wdog_q == WD_W'(TIMEOUT_CYC - 1)) begin
          wdog_q        <= '0;
          state_q       <= IDLE;
          req_ready_q   <= 1'b1;
          rsp_err_q     <= 1'b1;
          rsp_valid_q   <= 1'b0;
          m_cmd_valid_q <= 1'b0;
          m_cmd_wr_q    <= 1'b0;
        end else begin
          wdog_q <= wdog_q + WD_W'(1);
        end
      end else begin
        wdog_q <= '0;
      end
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rd_blk  = rsp_rd_blk_q;
  assign m_cmd_valid = m_cmd_valid_q;
  assign m_cmd_wr    = m_cmd_wr_q;
  assign m_cmd_addr  = m_cmd_addr_q;
  assign m_wdata     = m_wdata_q;

endmodule
